// File: rtl/aes_sb_pkg.sv
// aes_sb_pkg: shared types and constants for the SubBytes/ShiftRows engine.
package aes_sb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } sb_state_t;

  localparam int BYTE_W      = 8;
  localparam int STATE_BYTES = 16;

  // Row-major byte position of row r, column c within the 16-byte state.
  function automatic int byte_idx(input int r, input int c);
    return 4 * r + c;
  endfunction

endpackage

// File: rtl/aes_shiftrows.sv
// aes_shiftrows: combinational ShiftRows / InvShiftRows on a 128-bit state.
// Byte i lives at [127-8i -: 8]; byte 4r+c is row r, column c.
module aes_shiftrows (
  input  logic [127:0] din,
  input  logic         inv,
  output logic [127:0] dout
);
  import aes_sb_pkg::*;

  // Row r rotates left by r for encrypt, right by r for decrypt.
  always_comb begin
    dout = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (inv)
          dout[127 - BYTE_W*byte_idx(r, c) -: BYTE_W] =
            din[127 - BYTE_W*byte_idx(r, (c + 4 - r) % 4) -: BYTE_W];
        else
          dout[127 - BYTE_W*byte_idx(r, c) -: BYTE_W] =
            din[127 - BYTE_W*byte_idx(r, (c + r) % 4) -: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/subbytes_shiftrows_engine.sv
// subbytes_shiftrows_engine: AES SubBytes + (Inv)ShiftRows round stage.
// Latches a state on start, streams LANES bytes per cycle to an external
// S-box memory with SBOX_LAT read latency, gathers the substituted bytes and
// loads the permuted result into data_out with a one-cycle ready pulse.
// Optional feature: define SBOX_PARITY_EN to add per-lane odd-parity checking
// of the returned S-box data (sbox_par_in / par_err_out).
module subbytes_shiftrows_engine #(
  parameter int LANES    = 1,
  parameter int SBOX_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_in,
  input  logic                 decrypt_in,
  input  logic [127:0]         data_in,
  input  logic [8*LANES-1:0]   sbox_data_in,
`ifdef SBOX_PARITY_EN
  input  logic [LANES-1:0]     sbox_par_in,
  output logic                 par_err_out,
`endif
  output logic [8*LANES-1:0]   sbox_addr_out,
  output logic                 sbox_inv_out,
  output logic                 sbox_ce,
  output logic                 sbox_re,
  output logic [127:0]         data_out,
  output logic                 ready_out,
  output logic                 busy_out
);
  import aes_sb_pkg::*;

  localparam int              BEATS     = STATE_BYTES / LANES;
  localparam int              CW        = 4;
  localparam logic [CW-1:0]   LAST_BEAT = CW'(BEATS - 1);

  sb_state_t       state;
  logic [CW-1:0]   beat;
  logic [127:0]    src_q;
  logic            dec_q;
  logic [127:0]    sub_q;
  logic [127:0]    sub_next;
  logic [127:0]    perm;
  logic            accept;
  logic            cap;
  logic [CW-1:0]   cap_idx;
  logic            last_cap;

  // Request tags: valid and beat index travelling alongside the S-box read.
  logic            vld_p [SBOX_LAT];
  logic [CW-1:0]   idx_p [SBOX_LAT];

  // Lane j of beat k addresses state byte k*LANES+j.
  function automatic logic [8*LANES-1:0] beat_bytes(input logic [127:0] v,
                                                    input logic [CW-1:0] k);
    logic [8*LANES-1:0] r;
    r = '0;
    for (int j = 0; j < LANES; j++)
      r[BYTE_W*j +: BYTE_W] = v[127 - BYTE_W*((int'(k)*LANES + j) & 15) -: BYTE_W];
    return r;
  endfunction

  // Write the lanes returned for beat k into their state byte positions.
  function automatic logic [127:0] merge_beat(input logic [127:0] b,
                                              input logic [8*LANES-1:0] d,
                                              input logic [CW-1:0] k);
    logic [127:0] r;
    r = b;
    for (int j = 0; j < LANES; j++)
      r[127 - BYTE_W*((int'(k)*LANES + j) & 15) -: BYTE_W] = d[BYTE_W*j +: BYTE_W];
    return r;
  endfunction

  assign accept       = (state == IDLE) && start_in;
  assign cap          = vld_p[SBOX_LAT-1];
  assign cap_idx      = idx_p[SBOX_LAT-1];
  assign last_cap     = cap && (cap_idx == LAST_BEAT);
  assign sub_next     = cap ? merge_beat(sub_q, sbox_data_in, cap_idx) : sub_q;
  assign sbox_inv_out = dec_q;

  // The final beat is merged and permuted on the same edge it is captured.
  aes_shiftrows u_shiftrows (
    .din  (sub_next),
    .inv  (dec_q),
    .dout (perm)
  );

  // Tag pipe: stage 0 is loaded with the beat issued this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SBOX_LAT; s++) begin
        vld_p[s] <= 1'b0;
        idx_p[s] <= '0;
      end
    end else begin
      vld_p[0] <= (state == ISSUE);
      idx_p[0] <= beat;
      for (int s = 1; s < SBOX_LAT; s++) begin
        vld_p[s] <= vld_p[s-1];
        idx_p[s] <= idx_p[s-1];
      end
    end
  end

  // Job operand and substitution buffer; contents matter only during a job.
  always_ff @(posedge clk) begin
    if (accept)
      src_q <= data_in;
    sub_q <= sub_next;
  end

  // Control FSM with registered S-box interface and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      beat          <= '0;
      dec_q         <= 1'b0;
      data_out      <= '0;
      ready_out     <= 1'b0;
      busy_out      <= 1'b0;
      sbox_ce       <= 1'b1;
      sbox_re       <= 1'b1;
      sbox_addr_out <= '0;
    end else begin
      ready_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            dec_q         <= decrypt_in;
            beat          <= '0;
            busy_out      <= 1'b1;
            sbox_ce       <= 1'b0;
            sbox_re       <= 1'b0;
            sbox_addr_out <= beat_bytes(data_in, '0);
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (beat == LAST_BEAT) begin
            sbox_ce       <= 1'b1;
            sbox_re       <= 1'b1;
            sbox_addr_out <= '0;
            state         <= DRAIN;
          end else begin
            beat          <= beat + 1'b1;
            sbox_addr_out <= beat_bytes(src_q, beat + 1'b1);
          end
        end
        DRAIN: begin
          if (last_cap) begin
            data_out  <= perm;
            ready_out <= 1'b1;
            busy_out  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SBOX_PARITY_EN
  logic par_bad;

  // Odd parity: data bits plus parity bit must XOR to 1 on every lane.
  function automatic logic lanes_par_err(input logic [8*LANES-1:0] d,
                                         input logic [LANES-1:0] p);
    logic e;
    e = 1'b0;
    for (int j = 0; j < LANES; j++)
      e = e | ~(^{d[BYTE_W*j +: BYTE_W], p[j]});
    return e;
  endfunction

  assign par_bad = cap && lanes_par_err(sbox_data_in, sbox_par_in);

  // Sticky parity error, cleared when a new job is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      par_err_out <= 1'b0;
    else if (accept)
      par_err_out <= 1'b0;
    else if (par_bad)
      par_err_out <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_subbytes_shiftrows_engine.sv
// tb_subbytes_shiftrows_engine: three engine configurations driven by shared
// stimulus, each with its own S-box memory, checked every cycle against a
// job-level model built from AES field arithmetic.
module tb_subbytes_shiftrows_engine;

  localparam int NI = 3;

  function automatic int cfg_lanes(input int g);
    case (g)
      0:       return 1;
      1:       return 4;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_lat(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         dec;
  logic [127:0] din;
`ifdef SBOX_PARITY_EN
  logic         par_flip;
  logic         q_perr [NI];
  logic         m_perr [NI];
  logic [15:0]  m_fm   [NI];
`endif

  logic [127:0] q_dout [NI];
  logic [127:0] q_addr [NI];
  logic         q_rdy  [NI];
  logic         q_busy [NI];
  logic         q_ce   [NI];
  logic         q_re   [NI];
  logic         q_inv  [NI];

  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [7:0]   t_p;
  logic [7:0]   t_s;

  int           n_vec = 0;
  int           n_bad = 0;
  logic         pinned = 1'b0;

  // model state
  logic         m_busy [NI];
  logic         m_rdy  [NI];
  logic         m_dec  [NI];
  int           m_cnt  [NI];
  logic [127:0] m_src  [NI];
  logic [127:0] m_out  [NI];

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // SubBytes on every byte, then rotate row r by r (left enc, right dec).
  function automatic logic [127:0] model_result(input logic [127:0] x, input logic inv);
    logic [7:0]   s [16];
    logic [127:0] r;
    int           col;
    r = '0;
    for (int i = 0; i < 16; i++)
      s[i] = inv ? isb[x[127 - 8*i -: 8]] : sb[x[127 - 8*i -: 8]];
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++) begin
        col = inv ? (c - row + 4) % 4 : (c + row) % 4;
        r[127 - 8*(4*row + c) -: 8] = s[4*row + col];
      end
    return r;
  endfunction

  function automatic logic [127:0] model_addr(input logic [127:0] x, input int k, input int l);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < l; j++)
      r[8*j +: 8] = x[127 - 8*(k*l + j) -: 8];
    return r;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_cfg
    localparam int L = cfg_lanes(g);
    localparam int S = cfg_lat(g);
    logic [8*L-1:0] addr;
    logic [8*L-1:0] look;
    logic [8*L-1:0] rd_p [S];
    logic           ce, re, inv, rdy, bsy;
    logic [127:0]   dout;
`ifdef SBOX_PARITY_EN
    logic [L-1:0]   look_par;
    logic [L-1:0]   par_p [S];
    logic           perr;
`endif

    subbytes_shiftrows_engine #(.LANES(L), .SBOX_LAT(S)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .start_in      (start),
      .decrypt_in    (dec),
      .data_in       (din),
      .sbox_data_in  (rd_p[S-1]),
`ifdef SBOX_PARITY_EN
      .sbox_par_in   (par_p[S-1]),
      .par_err_out   (perr),
`endif
      .sbox_addr_out (addr),
      .sbox_inv_out  (inv),
      .sbox_ce       (ce),
      .sbox_re       (re),
      .data_out      (dout),
      .ready_out     (rdy),
      .busy_out      (bsy)
    );

    always_comb begin
      look = '0;
      for (int j = 0; j < L; j++)
        look[8*j +: 8] = inv ? isb[addr[8*j +: 8]] : sb[addr[8*j +: 8]];
    end

    always @(posedge clk) begin
      rd_p[0] <= (!ce && !re) ? look : '0;
      for (int s = 1; s < S; s++) rd_p[s] <= rd_p[s-1];
    end

`ifdef SBOX_PARITY_EN
    always_comb begin
      look_par = '0;
      for (int j = 0; j < L; j++) look_par[j] = ~(^look[8*j +: 8]);
      look_par[0] = look_par[0] ^ par_flip;
    end

    always @(posedge clk) begin
      par_p[0] <= look_par;
      for (int s = 1; s < S; s++) par_p[s] <= par_p[s-1];
    end

    assign q_perr[g] = perr;
`endif

    assign q_dout[g] = dout;
    assign q_addr[g] = 128'(addr);
    assign q_rdy[g]  = rdy;
    assign q_busy[g] = bsy;
    assign q_ce[g]   = ce;
    assign q_re[g]   = re;
    assign q_inv[g]  = inv;
  end

  // Job-level model: a job accepted at edge 0 finishes at edge N+LAT.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_busy[i] <= 1'b0;
        m_rdy[i]  <= 1'b0;
        m_dec[i]  <= 1'b0;
        m_cnt[i]  <= 0;
        m_out[i]  <= '0;
`ifdef SBOX_PARITY_EN
        m_perr[i] <= 1'b0;
        m_fm[i]   <= '0;
`endif
      end else begin
        m_rdy[i] <= 1'b0;
        if (m_busy[i]) begin
          m_cnt[i] <= m_cnt[i] + 1;
`ifdef SBOX_PARITY_EN
          if (m_cnt[i] < 16 / cfg_lanes(i) && par_flip)
            m_fm[i][4'(m_cnt[i])] <= 1'b1;
          if (m_cnt[i] - cfg_lat(i) >= 0 && m_cnt[i] - cfg_lat(i) < 16 / cfg_lanes(i))
            if (m_fm[i][4'(m_cnt[i] - cfg_lat(i))]) m_perr[i] <= 1'b1;
`endif
          if (m_cnt[i] + 1 == 16 / cfg_lanes(i) + cfg_lat(i)) begin
            m_busy[i] <= 1'b0;
            m_rdy[i]  <= 1'b1;
            m_out[i]  <= model_result(m_src[i], m_dec[i]);
          end
        end else if (start) begin
          m_busy[i] <= 1'b1;
          m_cnt[i]  <= 0;
          m_src[i]  <= din;
          m_dec[i]  <= dec;
`ifdef SBOX_PARITY_EN
          m_perr[i] <= 1'b0;
          m_fm[i]   <= '0;
`endif
        end
      end
    end
  end

  task automatic check1(input int i, input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0t: got %b expected %b", nm, i, $time, act, exp);
    end
  endtask

  task automatic check128(input int i, input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0t: got %h expected %h", nm, i, $time, act, exp);
    end
  endtask

  // Compare every output of every instance on the falling edge.
  always @(negedge clk) begin
    if (!pinned) begin
      pinned = 1'b1;
      check128(0, "sbox_00", 128'(sb[8'h00]), 128'h63);
      check128(0, "sbox_53", 128'(sb[8'h53]), 128'hed);
      check128(0, "sbox_ff", 128'(sb[8'hff]), 128'h16);
      check128(0, "isbox_63", 128'(isb[8'h63]), 128'h00);
    end
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        check1(i, "rst_ready", q_rdy[i], 1'b0);
        check1(i, "rst_busy", q_busy[i], 1'b0);
        check1(i, "rst_ce", q_ce[i], 1'b1);
        check1(i, "rst_re", q_re[i], 1'b1);
        check1(i, "rst_inv", q_inv[i], 1'b0);
        check128(i, "rst_addr", q_addr[i], '0);
        check128(i, "rst_dout", q_dout[i], '0);
`ifdef SBOX_PARITY_EN
        check1(i, "rst_parerr", q_perr[i], 1'b0);
`endif
      end else begin
        check1(i, "ready", q_rdy[i], m_rdy[i]);
        check1(i, "busy", q_busy[i], m_busy[i]);
        check1(i, "inv", q_inv[i], m_dec[i]);
        check128(i, "dout", q_dout[i], m_out[i]);
        check1(i, "ce", q_ce[i], !(m_busy[i] && m_cnt[i] < 16 / cfg_lanes(i)));
        check1(i, "re", q_re[i], !(m_busy[i] && m_cnt[i] < 16 / cfg_lanes(i)));
        if (m_busy[i] && m_cnt[i] < 16 / cfg_lanes(i))
          check128(i, "addr", q_addr[i], model_addr(m_src[i], m_cnt[i], cfg_lanes(i)));
`ifdef SBOX_PARITY_EN
        check1(i, "parerr", q_perr[i], m_perr[i]);
`endif
        if (m_rdy[i]) begin
          check128(i, "latency", 128'(m_cnt[i]), (i == 0) ? 128'd17 : (i == 1) ? 128'd6 : 128'd4);
          if (m_src[i] == 128'h00112233445566778899aabbccddeeff && !m_dec[i])
            check128(i, "pin_enc", q_dout[i], 128'h638293c3fc33f51baceac4ee164bc128);
          if (m_src[i] == 128'h638293c3fc33f51baceac4ee164bc128 && m_dec[i])
            check128(i, "pin_dec", q_dout[i], 128'h00112233445566778899aabbccddeeff);
          if (m_src[i] == 128'h0 && !m_dec[i])
            check128(i, "pin_zero", q_dout[i], {16{8'h63}});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [127:0] d, input logic m);
    start = 1'b1;
    din   = d;
    dec   = m;
    tick();
    start = 1'b0;
    din   = {$urandom, $urandom, $urandom, $urandom};
    dec   = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    dec   = 1'b0;
    din   = '0;
`ifdef SBOX_PARITY_EN
    par_flip = 1'b0;
`endif
    // S-box from GF(2^8) inverse (x^254) followed by the affine map.
    for (int x = 0; x < 256; x++) begin
      t_p = 8'h01;
      for (int k = 0; k < 254; k++) t_p = gmul(t_p, 8'(x));
      t_s = t_p ^ {t_p[6:0], t_p[7]} ^ {t_p[5:0], t_p[7:6]} ^
            {t_p[4:0], t_p[7:5]} ^ {t_p[3:0], t_p[7:4]} ^ 8'h63;
      sb[x]   = t_s;
      isb[t_s] = 8'(x);
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();

    start_job(128'h00112233445566778899aabbccddeeff, 1'b0);
    repeat (20) tick();
    start_job(128'h638293c3fc33f51baceac4ee164bc128, 1'b1);
    repeat (20) tick();
    start_job(128'h0, 1'b0);
    repeat (20) tick();

    // start held high: back-to-back jobs, mid-job starts ignored
    start = 1'b1;
    for (int c = 0; c < 45; c++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      dec = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    repeat (20) tick();

    // asynchronous reset during issue beat 3
    start_job({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    start_job(128'h00112233445566778899aabbccddeeff, 1'b0);
    repeat (20) tick();

`ifdef SBOX_PARITY_EN
    start_job({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    repeat (5) tick();
    par_flip = 1'b1;
    tick();
    par_flip = 1'b0;
    repeat (20) tick();
    start_job({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    repeat (20) tick();
`endif

    for (int c = 0; c < 800; c++) begin
      start = ($urandom_range(0, 3) == 0);
      dec   = 1'($urandom_range(0, 1));
      din   = {$urandom, $urandom, $urandom, $urandom};
`ifdef SBOX_PARITY_EN
      par_flip = ($urandom_range(0, 15) == 0);
`endif
      tick();
    end
    start = 1'b0;
`ifdef SBOX_PARITY_EN
    par_flip = 1'b0;
`endif
    repeat (30) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
